// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register file write-port arbiter.
package regfile_wb_arbiter_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between stage 3, the long-latency unit, decode and the register file port.
interface regfile_wb_arbiter_if #(parameter int XLEN = regfile_wb_arbiter_pkg::XLEN);
    import regfile_wb_arbiter_pkg::*;

    logic                pipe_we;
    reg_idx_t            pipe_rd;
    logic [XLEN-1:0]     pipe_wdata;
    logic                lu_issue;
    reg_idx_t            lu_issue_rd;
    logic                lu_valid;
    reg_idx_t            lu_rd;
    logic [XLEN-1:0]     lu_wdata;
    logic                lu_ready;
    reg_idx_t            dec_rs1;
    reg_idx_t            dec_rs2;
    reg_idx_t            dec_rd;
    logic                dec_rd_we;
    logic                hazard_stall;
    logic                pipe_hold;
    logic                rf_we;
    reg_idx_t            rf_rd;
    logic [XLEN-1:0]     rf_wdata;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata, lu_issue, lu_issue_rd,
               lu_valid, lu_rd, lu_wdata, dec_rs1, dec_rs2, dec_rd, dec_rd_we,
        output lu_ready, hazard_stall, pipe_hold, rf_we, rf_rd, rf_wdata, pending
    );

    modport master (
        output pipe_we, pipe_rd, pipe_wdata, lu_issue, lu_issue_rd,
               lu_valid, lu_rd, lu_wdata, dec_rs1, dec_rs2, dec_rd, dec_rd_we,
        input  lu_ready, hazard_stall, pipe_hold, rf_we, rf_rd, rf_wdata, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for in-flight long-latency results; set beats clear on the same index.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  reg_idx_t            set_idx,
    input  logic                clr_en,
    input  reg_idx_t            clr_idx,
    input  reg_idx_t            rs1_idx,
    input  reg_idx_t            rs2_idx,
    input  reg_idx_t            rd_idx,
    output logic                rs1_pend,
    output logic                rs2_pend,
    output logic                rd_pend,
    output logic [NUM_REGS-1:0] pending
);
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending_q;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending_q <= '0;
        else        pending_q <= pending_nxt;
    end

    assign rs1_pend = (rs1_idx != '0) & pending_q[rs1_idx];
    assign rs2_pend = (rs2_idx != '0) & pending_q[rs2_idx];
    assign rd_pend  = (rd_idx  != '0) & pending_q[rd_idx];
    assign pending  = pending_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter: stage 3 has fixed priority, the long-latency unit waits, and a
// starvation counter forces a writeback bubble so the long-latency result always drains.
module regfile_wb_arbiter #(
    parameter int XLEN         = regfile_wb_arbiter_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    import regfile_wb_arbiter_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic            pipe_req;
    logic            lu_ready;
    logic            lu_commit;
    logic            rf_we;
    reg_idx_t        rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            rs1_pend, rs2_pend, rd_pend;
    logic [3:0]      starve_cnt, starve_nxt;
    logic            pipe_hold;

    assign pipe_req = bus.pipe_we & (bus.pipe_rd != '0);

    // Everything combinational is forced low while reset is held.
    always_comb begin
        lu_ready  = 1'b0;
        lu_commit = 1'b0;
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_wdata  = '0;
        if (reset) begin
            lu_ready = ~pipe_req;
            if (pipe_req) begin
                rf_we    = 1'b1;
                rf_rd    = bus.pipe_rd;
                rf_wdata = bus.pipe_wdata;
            end else if (bus.lu_valid) begin
                lu_commit = 1'b1;
                if (bus.lu_rd != '0) begin
                    rf_we    = 1'b1;
                    rf_rd    = bus.lu_rd;
                    rf_wdata = bus.lu_wdata;
                end
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.lu_valid || lu_commit) starve_nxt = '0;
        else if (starve_cnt < LIMIT)    starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            pipe_hold  <= (starve_nxt == LIMIT);
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (bus.lu_issue),
        .set_idx  (bus.lu_issue_rd),
        .clr_en   (lu_commit),
        .clr_idx  (bus.lu_rd),
        .rs1_idx  (bus.dec_rs1),
        .rs2_idx  (bus.dec_rs2),
        .rd_idx   (bus.dec_rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .pending  (bus.pending)
    );

    assign bus.hazard_stall = reset & (rs1_pend | rs2_pend | (bus.dec_rd_we & rd_pend));
    assign bus.lu_ready     = lu_ready;
    assign bus.rf_we        = rf_we;
    assign bus.rf_rd        = rf_rd;
    assign bus.rf_wdata     = rf_wdata;
    assign bus.pipe_hold    = pipe_hold;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expected values.
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_wdata = 0;
        bus.lu_issue = 0; bus.lu_issue_rd = 0;
        bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_wdata = 0;
        bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0; bus.dec_rd_we = 0;
    endtask

    // Stimulus must never issue to a register that is already pending.
    always @(posedge clk) begin
        if (reset && bus.lu_issue && bus.lu_issue_rd != 0) begin
            assert (bus.pending[bus.lu_issue_rd] === 1'b0) else begin
                errors++;
                $error("FAIL issue_to_pending rd %0d", bus.lu_issue_rd);
            end
        end
    end

    initial begin
        idle_inputs();
        reset = 1'b0;

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            bus.pipe_we = 1'($urandom); bus.pipe_rd = 5'($urandom); bus.pipe_wdata = $urandom;
            bus.lu_issue = 1'($urandom); bus.lu_issue_rd = 5'($urandom);
            bus.lu_valid = 1'($urandom); bus.lu_rd = 5'($urandom); bus.lu_wdata = $urandom;
            bus.dec_rs1 = 5'($urandom); bus.dec_rs2 = 5'($urandom);
            bus.dec_rd = 5'($urandom); bus.dec_rd_we = 1'($urandom);
            tick();
            check("rst_rf_we", 32'(bus.rf_we), 0);
            check("rst_lu_ready", 32'(bus.lu_ready), 0);
            check("rst_stall", 32'(bus.hazard_stall), 0);
            check("rst_pending", bus.pending, 0);
        end
        check("rst_pipe_hold", 32'(bus.pipe_hold), 0);
        idle_inputs();
        #4 reset = 1'b1;
        tick();

        // first pipe write after reset
        bus.pipe_we = 1; bus.pipe_rd = 1; bus.pipe_wdata = 32'hA5;
        #1;
        check("pipe_rf_we", 32'(bus.rf_we), 1);
        check("pipe_rf_rd", 32'(bus.rf_rd), 1);
        check("pipe_rf_wdata", bus.rf_wdata, 32'hA5);
        tick();
        idle_inputs();

        // RAW / WAW on a pending long-latency destination
        bus.lu_issue = 1; bus.lu_issue_rd = 5;
        tick();
        bus.lu_issue = 0; bus.dec_rs1 = 5;
        #1;
        check("raw_stall_rs1", 32'(bus.hazard_stall), 1);
        check("raw_pending", bus.pending, 32'h0000_0020);
        bus.dec_rs1 = 0; bus.dec_rs2 = 5; #1;
        check("raw_stall_rs2", 32'(bus.hazard_stall), 1);
        bus.dec_rs2 = 0; bus.dec_rd = 5; bus.dec_rd_we = 0; #1;
        check("waw_no_we", 32'(bus.hazard_stall), 0);
        bus.dec_rd_we = 1; #1;
        check("waw_stall", 32'(bus.hazard_stall), 1);
        bus.dec_rd_we = 0; bus.dec_rd = 0; bus.dec_rs1 = 5;
        bus.lu_valid = 1; bus.lu_rd = 5; bus.lu_wdata = 32'hDEADBEEF;
        #1;
        check("raw_commit_we", 32'(bus.rf_we), 1);
        check("raw_commit_rd", 32'(bus.rf_rd), 5);
        check("raw_commit_data", bus.rf_wdata, 32'hDEADBEEF);
        check("raw_stall_during_commit", 32'(bus.hazard_stall), 1);
        tick();
        bus.lu_valid = 0;
        #1;
        check("raw_pending_clr", bus.pending, 0);
        check("raw_stall_clr", 32'(bus.hazard_stall), 0);
        idle_inputs();

        // pipe vs long-latency conflict
        bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_wdata = 32'h11;
        bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_wdata = 32'h22;
        #1;
        check("conf_rf_rd", 32'(bus.rf_rd), 3);
        check("conf_rf_wdata", bus.rf_wdata, 32'h11);
        check("conf_lu_ready0", 32'(bus.lu_ready), 0);
        tick();
        bus.pipe_we = 0;
        #1;
        check("conf_lu_rd", 32'(bus.rf_rd), 7);
        check("conf_lu_wdata", bus.rf_wdata, 32'h22);
        check("conf_lu_ready1", 32'(bus.lu_ready), 1);
        tick();
        idle_inputs();

        // starvation with STARVE_LIMIT=4
        bus.pipe_we = 1; bus.pipe_rd = 2; bus.pipe_wdata = 32'h44;
        bus.lu_valid = 1; bus.lu_rd = 12; bus.lu_wdata = 32'h33;
        tick(); tick(); tick();
        check("starve_3_hold", 32'(bus.pipe_hold), 0);
        tick();
        check("starve_4_hold", 32'(bus.pipe_hold), 1);
        bus.pipe_we = 0;
        #1;
        check("starve_grant_ready", 32'(bus.lu_ready), 1);
        check("starve_grant_rd", 32'(bus.rf_rd), 12);
        tick();
        bus.lu_valid = 0;
        #1;
        check("starve_hold_drop", 32'(bus.pipe_hold), 0);

        // counter clears when lu_valid drops
        bus.pipe_we = 1; bus.lu_valid = 1;
        tick(); tick(); tick();
        bus.lu_valid = 0;
        tick();
        bus.lu_valid = 1;
        tick(); tick(); tick();
        check("starve_valid_clr", 32'(bus.pipe_hold), 0);
        bus.pipe_we = 0;
        tick();
        idle_inputs();

        // x0 handling
        bus.lu_issue = 1; bus.lu_issue_rd = 0;
        tick();
        bus.lu_issue = 0;
        check("x0_issue_pending", bus.pending, 0);
        bus.pipe_we = 1; bus.pipe_rd = 0; bus.pipe_wdata = 32'h77;
        bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_wdata = 32'h99;
        #1;
        check("x0_pipe_lu_ready", 32'(bus.lu_ready), 1);
        check("x0_pipe_rf_rd", 32'(bus.rf_rd), 9);
        check("x0_pipe_rf_wdata", bus.rf_wdata, 32'h99);
        tick();
        bus.pipe_we = 0; bus.lu_rd = 0;
        #1;
        check("x0_lu_ready", 32'(bus.lu_ready), 1);
        check("x0_lu_rf_we", 32'(bus.rf_we), 0);
        tick();
        idle_inputs();

        // simultaneous set and clear of the same index: set wins
        bus.lu_issue = 1; bus.lu_issue_rd = 8;
        bus.lu_valid = 1; bus.lu_rd = 8; bus.lu_wdata = 32'h88;
        tick();
        idle_inputs();
        #1;
        check("set_wins", bus.pending, 32'h0000_0100);
        bus.lu_valid = 1; bus.lu_rd = 8;
        tick();
        idle_inputs();

        // async reset mid-operation
        bus.lu_issue = 1; bus.lu_issue_rd = 5;
        tick();
        bus.lu_issue = 0;
        bus.pipe_we = 1; bus.pipe_rd = 2; bus.pipe_wdata = 32'h55;
        bus.lu_valid = 1; bus.lu_rd = 10; bus.lu_wdata = 32'h66;
        tick(); tick(); tick();
        check("mid_pending_set", bus.pending, 32'h0000_0020);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pending", bus.pending, 0);
        check("mid_rst_hold", 32'(bus.pipe_hold), 0);
        check("mid_rst_rf_we", 32'(bus.rf_we), 0);
        #1 reset = 1'b1;
        bus.pipe_we = 0; bus.lu_valid = 0; bus.dec_rs1 = 5;
        #1;
        check("mid_rel_stall", 32'(bus.hazard_stall), 0);
        bus.dec_rs1 = 0; bus.pipe_we = 1; bus.lu_valid = 1;
        tick(); tick(); tick();
        check("mid_cnt_cleared", 32'(bus.pipe_hold), 0);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controls the single write port of the 32x32 integer register file. It shares that port between two requesters: the stage-3 pipeline writeback, and a long-latency unit (mul/div, late loads) that uses a valid/ready handshake. It also keeps a pending-write scoreboard so decode can stall on RAW and WAW hazards against in-flight long-latency results. It sits between stage 3, the long-latency unit, the decode hazard logic and the register file write port.

Parameters:
XLEN, 32, data width
STARVE_LIMIT, 4, consecutive denied cycles of a long-latency write before pipe_hold asserts (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pipe_we  in  1  stage-3 writeback valid
pipe_rd  in  5  stage-3 destination register
pipe_wdata  in  XLEN  stage-3 writeback data
lu_issue  in  1  long-latency op issued this cycle
lu_issue_rd  in  5  destination of the issued op
lu_valid  in  1  long-latency result available
lu_rd  in  5  result destination
lu_wdata  in  XLEN  result data
lu_ready  out  1  result accepted this cycle
dec_rs1  in  5  decode source 1
dec_rs2  in  5  decode source 2
dec_rd  in  5  decode destination
dec_rd_we  in  1  decode instruction writes dec_rd
hazard_stall  out  1  decode must stall
pipe_hold  out  1  pipeline must insert a writeback bubble next cycle
rf_we  out  1  register file write enable
rf_rd  out  5  register file write index
rf_wdata  out  XLEN  register file write data
pending  out  32  scoreboard bits (debug); bit 0 is always 0

Behaviour:
- Reset (reset=0, async): pending=0, starvation counter=0, pipe_hold=0. All combinational outputs evaluate to 0 while reset=0, including rf_we, lu_ready and hazard_stall.
- Request qualification:
  - pipe_req = pipe_we & (pipe_rd!=0).
  - A stage-3 write to x0 is treated as no request.
- Arbitration (combinational, zero latency; the register file writes on the next posedge):
  - pipe_req has fixed priority: rf_we=1, rf_rd=pipe_rd, rf_wdata=pipe_wdata.
  - lu_ready = ~pipe_req.
  - If lu_valid & lu_ready & lu_rd!=0: rf_we=1, rf_rd=lu_rd, rf_wdata=lu_wdata.
  - If lu_valid & lu_ready & lu_rd==0: the result is consumed and rf_we=0.
  - When idle: rf_we=0, rf_rd=0, rf_wdata=0.
- Long-latency unit handshake: lu_rd and lu_wdata are held stable while lu_valid=1 and lu_ready=0. Commit occurs on a posedge with lu_valid&lu_ready.
- Scoreboard:
  - On posedge with lu_issue & lu_issue_rd!=0: set pending[lu_issue_rd].
  - On lu commit: clear pending[lu_rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is hardwired 0.
- Hazard (combinational):
  - hazard_stall = (dec_rs1!=0 & pending[dec_rs1]) | (dec_rs2!=0 & pending[dec_rs2]) | (dec_rd_we & dec_rd!=0 & pending[dec_rd]).
  - A commit in the current cycle does not suppress the stall; the stall drops the cycle after the commit. No forwarding is done from the long-latency path.
- Issue rule: lu_issue is only asserted when hazard_stall=0. lu_issue to an already-pending rd is an error; the bench asserts on it.
- Starvation counter:
  - 4-bit counter that increments each cycle with lu_valid & ~lu_ready, saturating at STARVE_LIMIT.
  - Clears on an lu commit or when lu_valid=0.
  - pipe_hold is a registered output, 1 while count==STARVE_LIMIT.
  - The pipeline guarantees pipe_we=0 in any cycle where pipe_hold=1. The lu write is therefore granted, and pipe_hold falls on the following posedge.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NUM_REGS=32, and a reg_idx_t typedef.
- One sub-module, regfile_scoreboard: pending bits with set/clear ports and three combinational lookup ports (rs1, rs2, rd).
- Arbitration and starvation logic stay in the top.

Test Plan:
- Reset: hold reset=0 with random inputs -> rf_we=0, lu_ready=0, hazard_stall=0, pending=0; after release, pipe_we=1 pipe_rd=1 pipe_wdata=0xA5 -> rf_we=1 rf_rd=1 rf_wdata=0xA5 in the same cycle.
- RAW: lu_issue rd=5, then dec_rs1=5 -> hazard_stall=1; lu_valid rd=5 wdata=0xDEADBEEF with pipe_we=0 -> rf_we=1 rf_rd=5, pending[5]=0 and hazard_stall=0 on the next cycle.
- Conflict: pipe_we rd=3 data=0x11 plus lu_valid rd=7 data=0x22 -> rf_rd=3, lu_ready=0; next cycle with pipe_we=0 -> rf_rd=7 rf_wdata=0x22, lu_ready=1.
- Starvation, STARVE_LIMIT=4: pipe_we rd=2 every cycle, lu_valid held -> pipe_hold=1 after 4 denied cycles; drive pipe_we=0 -> lu commits, pipe_hold=0 next cycle.
- x0: lu_issue rd=0 -> pending unchanged; pipe_we rd=0 with lu_valid rd=9 -> lu_ready=1, rf_rd=9; lu_valid rd=0 -> lu_ready=1, rf_we=0.
- Async reset mid-operation: pending[5]=1 and counter at 3, pulse reset=0 between clock edges -> pending=0, pipe_hold=0 immediately; hazard_stall=0 for dec_rs1=5 after release.
